// File: rtl/i2c_write_master.sv
// i2c_write_master: open-drain I2C master for single-register writes (START, device, addr, data, STOP)
//   clk      in     system clock
//   reset_n  in     asynchronous active-low reset; releases both bus lines immediately
//   scl/sda  inout  open-drain bus lines, driven 0 or released
//   valid    in     command available; {device, addr, data} captured when accepted
//   ready    out    idle, a command is accepted on the next rising edge if valid
//   device   in     first byte, sent verbatim (address + R/W bit)
//   addr     in     register address byte
//   data     in     register data byte
//   nack     out    sticky NACK flag, cleared on acceptance
// Macro I2C_ACK_CHECK_EN: when defined, a NACK sets nack and cuts the transfer short with STOP;
// when undefined, ACK slots are ignored and nack stays 0.
module i2c_write_master #(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       reset_n,
    inout  logic       scl,
    inout  logic       sda,
    input  logic       valid,
    output logic       ready,
    input  logic [7:0] device,
    input  logic [7:0] addr,
    input  logic [7:0] data,
    output logic       nack
);
`ifdef I2C_ACK_CHECK_EN
    localparam logic ACK_CHECK = 1'b1;
`else
    localparam logic ACK_CHECK = 1'b0;
`endif
    localparam int CW = $clog2(CLK_DIV);

    typedef enum logic [1:0] {IDLE, START, BIT, STOP} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    qtr_q;
    logic [3:0]    bit_q;
    logic [1:0]    byte_q;
    logic [23:0]   sh_q;
    logic          ready_q;
    logic          nack_q;
    logic          scl_lo_q;
    logic          sda_lo_q;

    assign scl   = scl_lo_q ? 1'b0 : 1'bz;
    assign sda   = sda_lo_q ? 1'b0 : 1'bz;
    assign ready = ready_q;
    assign nack  = nack_q;

    // Line drives are registered and updated on the edge that opens each quarter.
    // bit_q is the slot within a byte, 8 being the ACK slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            qtr_q    <= 2'd0;
            bit_q    <= 4'd0;
            byte_q   <= 2'd0;
            sh_q     <= 24'd0;
            ready_q  <= 1'b1;
            nack_q   <= 1'b0;
            scl_lo_q <= 1'b0;
            sda_lo_q <= 1'b0;
        end else if (state_q == IDLE) begin
            if (valid) begin
                sh_q    <= {device, addr, data};
                nack_q  <= 1'b0;
                cnt_q   <= '0;
                qtr_q   <= 2'd0;
                ready_q <= 1'b0;
                state_q <= START;
            end
        end else if (cnt_q != CW'(CLK_DIV - 1)) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
            qtr_q <= qtr_q + 2'd1;
            if (state_q == START) begin
                if (qtr_q == 2'd0) begin
                    sda_lo_q <= 1'b1;
                end else begin
                    state_q  <= BIT;
                    qtr_q    <= 2'd0;
                    bit_q    <= 4'd0;
                    byte_q   <= 2'd0;
                    scl_lo_q <= 1'b1;
                    sda_lo_q <= ~sh_q[23];
                    sh_q     <= {sh_q[22:0], 1'b0};
                end
            end else if (state_q == BIT) begin
                if (qtr_q == 2'd1) begin
                    scl_lo_q <= 1'b0;
                end else if (qtr_q == 2'd2) begin
                    // Edge closing q2 samples the slave's ACK from the last q2 cycle.
                    if (ACK_CHECK && bit_q == 4'd8 && sda) nack_q <= 1'b1;
                end else if (qtr_q == 2'd3) begin
                    scl_lo_q <= 1'b1;
                    if (bit_q == 4'd8 && (byte_q == 2'd2 || nack_q)) begin
                        state_q  <= STOP;
                        sda_lo_q <= 1'b1;
                    end else if (bit_q == 4'd7) begin
                        bit_q    <= 4'd8;
                        sda_lo_q <= 1'b0;
                    end else begin
                        bit_q    <= (bit_q == 4'd8) ? 4'd0 : bit_q + 4'd1;
                        byte_q   <= byte_q + {1'b0, bit_q == 4'd8};
                        sda_lo_q <= ~sh_q[23];
                        sh_q     <= {sh_q[22:0], 1'b0};
                    end
                end
            end else begin
                if (qtr_q == 2'd0) begin
                    scl_lo_q <= 1'b0;
                end else if (qtr_q == 2'd1) begin
                    sda_lo_q <= 1'b0;
                end else begin
                    state_q <= IDLE;
                    qtr_q   <= 2'd0;
                    ready_q <= 1'b1;
                end
            end
        end
    end
endmodule
